// File: rtl/dispatcher_pkg.sv
// dispatcher_pkg: shared widths, instruction class codes, dispatcher state
// encoding, the issue-bundle record and small class-decode helpers.
//   ROB_W / DATA_W   : ROB tag and data widths (tag 0 means "value ready")
//   inst_type_e      : decoded instruction class
//   state_e          : EMPTY (pass-through) / HOLD (one entry waiting)
//   issue_t          : fields sent to the RS or the LSB
package dispatcher_pkg;

    localparam int ROB_W           = 4;
    localparam int DATA_W          = 32;
    localparam int INST_TYPE_WIDTH = 4;

    localparam logic [ROB_W-1:0] NULL_TAG = '0;
    localparam logic             ENABLE   = 1'b1;
    localparam logic             DISABLE  = 1'b0;

    typedef enum logic [INST_TYPE_WIDTH-1:0] {
        INST_LUI     = 4'd0,
        INST_AUIPC   = 4'd1,
        INST_JAL     = 4'd2,
        INST_JALR    = 4'd3,
        INST_BRANCH  = 4'd4,
        INST_LOAD    = 4'd5,
        INST_STORE   = 4'd6,
        INST_ALU_IMM = 4'd7,
        INST_ALU_REG = 4'd8
    } inst_type_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] vj;
        logic [ROB_W-1:0]  qj;
        logic [DATA_W-1:0] vk;
        logic [ROB_W-1:0]  qk;
        inst_type_e        inst_type;
        logic [DATA_W-1:0] a;
        logic [ROB_W-1:0]  dest;
        logic [DATA_W-1:0] pc;
    } issue_t;

    function automatic logic uses_rs1(inst_type_e t);
        return !(t inside {INST_LUI, INST_AUIPC, INST_JAL});
    endfunction

    function automatic logic uses_rs2(inst_type_e t);
        return t inside {INST_ALU_REG, INST_BRANCH, INST_STORE};
    endfunction

    function automatic logic writes_rd(inst_type_e t);
        return !(t inside {INST_BRANCH, INST_STORE});
    endfunction

    function automatic logic is_mem(inst_type_e t);
        return t inside {INST_LOAD, INST_STORE};
    endfunction

endpackage

// File: rtl/dispatcher_if.sv
// dispatcher_if: every handshake and bus signal around the dispatcher.
//   iq_*         : decoded instruction in, iq_rdy_out back-pressure
//   rob_*        : ROB allocate, free/tag, value query/answer
//   reg_*        : register-status query/answer and rename
//   rs_* / dispatcher_* : reservation-station slot ready and issue bundle
//   lsb_*        : load/store buffer slot ready and issue bundle
//   cdb_*        : the two result broadcast buses
// Handshake: an instruction moves when iq_en_in and iq_rdy_out are both high
// at a rising edge; *_en_out outputs are one-cycle pulses with no back-pressure,
// because rs_rdy_in / lsb_rdy_in already promise a free slot.
// modport master = dispatcher side, slave = surrounding pipeline.
interface dispatcher_if;
    import dispatcher_pkg::*;

    logic              iq_en_in;
    inst_type_e        iq_inst_type_in;
    logic [4:0]        iq_rd_in, iq_rs1_in, iq_rs2_in;
    logic [DATA_W-1:0] iq_imm_in, iq_pc_in;
    logic              iq_rdy_out;

    logic              rob_free_in;
    logic [ROB_W-1:0]  rob_tag_in;
    logic              rob_en_out;
    inst_type_e        rob_inst_type_out;
    logic [4:0]        rob_rd_out;
    logic [DATA_W-1:0] rob_pc_out;
    logic [ROB_W-1:0]  rob_q1_out, rob_q2_out;
    logic              rob_rdy1_in, rob_rdy2_in;
    logic [DATA_W-1:0] rob_val1_in, rob_val2_in;

    logic [4:0]        reg_rs1_out, reg_rs2_out;
    logic [ROB_W-1:0]  reg_q1_in, reg_q2_in;
    logic [DATA_W-1:0] reg_v1_in, reg_v2_in;
    logic              reg_rename_en_out;
    logic [4:0]        reg_rename_rd_out;
    logic [ROB_W-1:0]  reg_rename_tag_out;

    logic              rs_rdy_in, lsb_rdy_in;

    logic              dispatcher_en_out;
    logic [DATA_W-1:0] dispatcher_vj_out, dispatcher_vk_out, dispatcher_A_out, dispatcher_pc_out;
    logic [ROB_W-1:0]  dispatcher_qj_out, dispatcher_qk_out, dispatcher_dest_out;
    inst_type_e        dispatcher_inst_type_out;

    logic              lsb_en_out;
    logic [DATA_W-1:0] lsb_vj_out, lsb_vk_out, lsb_A_out, lsb_pc_out;
    logic [ROB_W-1:0]  lsb_qj_out, lsb_qk_out, lsb_dest_out;
    inst_type_e        lsb_inst_type_out;

    logic              cdb_alu_en_in, cdb_lbuffer_en_in;
    logic [ROB_W-1:0]  cdb_alu_dest_in, cdb_lbuffer_dest_in;
    logic [DATA_W-1:0] cdb_alu_value_in, cdb_lbuffer_value_in;

    modport master (
        input  iq_en_in, iq_inst_type_in, iq_rd_in, iq_rs1_in, iq_rs2_in, iq_imm_in, iq_pc_in,
        output iq_rdy_out,
        input  rob_free_in, rob_tag_in, rob_rdy1_in, rob_rdy2_in, rob_val1_in, rob_val2_in,
        output rob_en_out, rob_inst_type_out, rob_rd_out, rob_pc_out, rob_q1_out, rob_q2_out,
        input  reg_q1_in, reg_q2_in, reg_v1_in, reg_v2_in,
        output reg_rs1_out, reg_rs2_out, reg_rename_en_out, reg_rename_rd_out, reg_rename_tag_out,
        input  rs_rdy_in, lsb_rdy_in,
        output dispatcher_en_out, dispatcher_vj_out, dispatcher_qj_out, dispatcher_vk_out,
               dispatcher_qk_out, dispatcher_inst_type_out, dispatcher_A_out,
               dispatcher_dest_out, dispatcher_pc_out,
        output lsb_en_out, lsb_vj_out, lsb_qj_out, lsb_vk_out, lsb_qk_out, lsb_inst_type_out,
               lsb_A_out, lsb_dest_out, lsb_pc_out,
        input  cdb_alu_en_in, cdb_alu_dest_in, cdb_alu_value_in,
               cdb_lbuffer_en_in, cdb_lbuffer_dest_in, cdb_lbuffer_value_in
    );

    modport slave (
        output iq_en_in, iq_inst_type_in, iq_rd_in, iq_rs1_in, iq_rs2_in, iq_imm_in, iq_pc_in,
        input  iq_rdy_out,
        output rob_free_in, rob_tag_in, rob_rdy1_in, rob_rdy2_in, rob_val1_in, rob_val2_in,
        input  rob_en_out, rob_inst_type_out, rob_rd_out, rob_pc_out, rob_q1_out, rob_q2_out,
        output reg_q1_in, reg_q2_in, reg_v1_in, reg_v2_in,
        input  reg_rs1_out, reg_rs2_out, reg_rename_en_out, reg_rename_rd_out, reg_rename_tag_out,
        output rs_rdy_in, lsb_rdy_in,
        input  dispatcher_en_out, dispatcher_vj_out, dispatcher_qj_out, dispatcher_vk_out,
               dispatcher_qk_out, dispatcher_inst_type_out, dispatcher_A_out,
               dispatcher_dest_out, dispatcher_pc_out,
        input  lsb_en_out, lsb_vj_out, lsb_qj_out, lsb_vk_out, lsb_qk_out, lsb_inst_type_out,
               lsb_A_out, lsb_dest_out, lsb_pc_out,
        output cdb_alu_en_in, cdb_alu_dest_in, cdb_alu_value_in,
               cdb_lbuffer_en_in, cdb_lbuffer_dest_in, cdb_lbuffer_value_in
    );

endinterface

// File: rtl/dispatcher_operand_resolve.sv
// dispatcher_operand_resolve: combinational priority mux for one source operand.
//   use_in, rs_in        : source is used by this class / architectural index
//   reg_q_in, reg_v_in   : register-status tag and architectural value
//   rob_rdy_in/val_in    : ROB already holds the result for reg_q_in
//   cdb_*                : both broadcast buses
//   q_out, v_out         : resolved tag (0 = ready) and value
// Priority: unused or x0, then tag already 0, then ROB, then either CDB bus.
module dispatcher_operand_resolve
    import dispatcher_pkg::*;
(
    input  logic              use_in,
    input  logic [4:0]        rs_in,
    input  logic [ROB_W-1:0]  reg_q_in,
    input  logic [DATA_W-1:0] reg_v_in,
    input  logic              rob_rdy_in,
    input  logic [DATA_W-1:0] rob_val_in,
    input  logic              cdb_alu_en_in,
    input  logic [ROB_W-1:0]  cdb_alu_dest_in,
    input  logic [DATA_W-1:0] cdb_alu_value_in,
    input  logic              cdb_lbuffer_en_in,
    input  logic [ROB_W-1:0]  cdb_lbuffer_dest_in,
    input  logic [DATA_W-1:0] cdb_lbuffer_value_in,
    output logic [ROB_W-1:0]  q_out,
    output logic [DATA_W-1:0] v_out
);

    always_comb begin
        q_out = NULL_TAG;
        v_out = '0;
        if (use_in && rs_in != 5'd0) begin
            if (reg_q_in == NULL_TAG) begin
                v_out = reg_v_in;
            end else if (rob_rdy_in) begin
                v_out = rob_val_in;
            end else if (cdb_alu_en_in && cdb_alu_dest_in == reg_q_in) begin
                v_out = cdb_alu_value_in;
            end else if (cdb_lbuffer_en_in && cdb_lbuffer_dest_in == reg_q_in) begin
                v_out = cdb_lbuffer_value_in;
            end else begin
                q_out = reg_q_in;
            end
        end
    end

endmodule

// File: rtl/dispatcher.sv
// dispatcher: issue stage. Accepts one decoded instruction per cycle,
// allocates the ROB entry, resolves operands, renames rd and issues to the
// RS (ALU/branch/jump) or the LSB (load/store). One hold register absorbs a
// busy target and keeps snooping both CDB buses while it waits.
//   clk_in, rst_in (async, active-low), rdy_in (global freeze),
//   rob_flush_in (discard everything), bus (dispatcher_if.master),
//   state_out (current FSM state, for observation).
module dispatcher
    import dispatcher_pkg::*;
(
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         rob_flush_in,
    dispatcher_if.master bus,
    output state_e       state_out
);

    state_e            state_q;
    issue_t            hold_q, out_q, entry;
    logic              hold_mem_q, rs_en_q, lsb_en_q, rob_en_q, ren_en_q;
    inst_type_e        rob_type_q;
    logic [4:0]        rob_rd_q, ren_rd_q;
    logic [DATA_W-1:0] rob_pc_q;
    logic [ROB_W-1:0]  ren_tag_q;

    logic              in_hold, iq_rdy, tgt_mem, tgt_rdy;
    logic              s1_use, s2_use, s1_rob_rdy, s2_rob_rdy;
    logic [4:0]        s1_rs, s2_rs;
    logic [ROB_W-1:0]  s1_q, s2_q, r1_q, r2_q;
    logic [DATA_W-1:0] s1_v, s2_v, r1_v, r2_v;

    assign in_hold = (state_q == ST_HOLD);
    assign iq_rdy  = !in_hold && bus.rob_free_in;

    // In HOLD the same resolvers re-run on the held tags: a nonzero dummy
    // index and no ROB answer leave only the "tag 0" and CDB-hit paths live.
    assign s1_use     = in_hold ? 1'b1      : uses_rs1(bus.iq_inst_type_in);
    assign s2_use     = in_hold ? 1'b1      : uses_rs2(bus.iq_inst_type_in);
    assign s1_rs      = in_hold ? 5'd1      : bus.iq_rs1_in;
    assign s2_rs      = in_hold ? 5'd1      : bus.iq_rs2_in;
    assign s1_q       = in_hold ? hold_q.qj : bus.reg_q1_in;
    assign s2_q       = in_hold ? hold_q.qk : bus.reg_q2_in;
    assign s1_v       = in_hold ? hold_q.vj : bus.reg_v1_in;
    assign s2_v       = in_hold ? hold_q.vk : bus.reg_v2_in;
    assign s1_rob_rdy = in_hold ? 1'b0      : bus.rob_rdy1_in;
    assign s2_rob_rdy = in_hold ? 1'b0      : bus.rob_rdy2_in;

    dispatcher_operand_resolve u_src1 (
        .use_in(s1_use), .rs_in(s1_rs), .reg_q_in(s1_q), .reg_v_in(s1_v),
        .rob_rdy_in(s1_rob_rdy), .rob_val_in(bus.rob_val1_in),
        .cdb_alu_en_in(bus.cdb_alu_en_in), .cdb_alu_dest_in(bus.cdb_alu_dest_in),
        .cdb_alu_value_in(bus.cdb_alu_value_in),
        .cdb_lbuffer_en_in(bus.cdb_lbuffer_en_in), .cdb_lbuffer_dest_in(bus.cdb_lbuffer_dest_in),
        .cdb_lbuffer_value_in(bus.cdb_lbuffer_value_in),
        .q_out(r1_q), .v_out(r1_v)
    );

    dispatcher_operand_resolve u_src2 (
        .use_in(s2_use), .rs_in(s2_rs), .reg_q_in(s2_q), .reg_v_in(s2_v),
        .rob_rdy_in(s2_rob_rdy), .rob_val_in(bus.rob_val2_in),
        .cdb_alu_en_in(bus.cdb_alu_en_in), .cdb_alu_dest_in(bus.cdb_alu_dest_in),
        .cdb_alu_value_in(bus.cdb_alu_value_in),
        .cdb_lbuffer_en_in(bus.cdb_lbuffer_en_in), .cdb_lbuffer_dest_in(bus.cdb_lbuffer_dest_in),
        .cdb_lbuffer_value_in(bus.cdb_lbuffer_value_in),
        .q_out(r2_q), .v_out(r2_v)
    );

    always_comb begin
        if (in_hold) begin
            entry = hold_q;
        end else begin
            entry           = '0;
            entry.inst_type = bus.iq_inst_type_in;
            entry.a         = bus.iq_imm_in;
            entry.dest      = bus.rob_tag_in;
            entry.pc        = bus.iq_pc_in;
        end
        entry.vj = r1_v;
        entry.qj = r1_q;
        entry.vk = r2_v;
        entry.qk = r2_q;
    end

    assign tgt_mem = in_hold ? hold_mem_q : is_mem(bus.iq_inst_type_in);
    assign tgt_rdy = tgt_mem ? bus.lsb_rdy_in : bus.rs_rdy_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_EMPTY;
            hold_q     <= '0;
            hold_mem_q <= 1'b0;
            out_q      <= '0;
            rs_en_q    <= DISABLE;
            lsb_en_q   <= DISABLE;
            rob_en_q   <= DISABLE;
            ren_en_q   <= DISABLE;
            rob_type_q <= INST_LUI;
            rob_rd_q   <= '0;
            rob_pc_q   <= '0;
            ren_rd_q   <= '0;
            ren_tag_q  <= NULL_TAG;
        end else begin
            // Every enable is a one-cycle pulse unless set again below.
            rs_en_q  <= DISABLE;
            lsb_en_q <= DISABLE;
            rob_en_q <= DISABLE;
            ren_en_q <= DISABLE;
            if (rdy_in) begin
                if (rob_flush_in) begin
                    state_q <= ST_EMPTY;
                end else if (!in_hold) begin
                    if (bus.iq_en_in && iq_rdy) begin
                        rob_en_q   <= ENABLE;
                        rob_type_q <= bus.iq_inst_type_in;
                        rob_rd_q   <= bus.iq_rd_in;
                        rob_pc_q   <= bus.iq_pc_in;
                        if (writes_rd(bus.iq_inst_type_in) && bus.iq_rd_in != 5'd0) begin
                            ren_en_q  <= ENABLE;
                            ren_rd_q  <= bus.iq_rd_in;
                            ren_tag_q <= bus.rob_tag_in;
                        end
                        if (tgt_rdy) begin
                            out_q    <= entry;
                            rs_en_q  <= !tgt_mem;
                            lsb_en_q <= tgt_mem;
                        end else begin
                            hold_q     <= entry;
                            hold_mem_q <= tgt_mem;
                            state_q    <= ST_HOLD;
                        end
                    end
                end else begin
                    if (tgt_rdy) begin
                        out_q    <= entry;
                        rs_en_q  <= !tgt_mem;
                        lsb_en_q <= tgt_mem;
                        state_q  <= ST_EMPTY;
                    end else begin
                        hold_q <= entry;
                    end
                end
            end
        end
    end

    assign state_out      = state_q;
    assign bus.iq_rdy_out = iq_rdy;

    assign bus.reg_rs1_out = bus.iq_rs1_in;
    assign bus.reg_rs2_out = bus.iq_rs2_in;
    assign bus.rob_q1_out  = bus.reg_q1_in;
    assign bus.rob_q2_out  = bus.reg_q2_in;

    assign bus.rob_en_out        = rob_en_q;
    assign bus.rob_inst_type_out = rob_type_q;
    assign bus.rob_rd_out        = rob_rd_q;
    assign bus.rob_pc_out        = rob_pc_q;

    assign bus.reg_rename_en_out  = ren_en_q;
    assign bus.reg_rename_rd_out  = ren_rd_q;
    assign bus.reg_rename_tag_out = ren_tag_q;

    // Both targets see the same registered fields; only the enables differ.
    assign bus.dispatcher_en_out        = rs_en_q;
    assign bus.dispatcher_vj_out        = out_q.vj;
    assign bus.dispatcher_qj_out        = out_q.qj;
    assign bus.dispatcher_vk_out        = out_q.vk;
    assign bus.dispatcher_qk_out        = out_q.qk;
    assign bus.dispatcher_inst_type_out = out_q.inst_type;
    assign bus.dispatcher_A_out         = out_q.a;
    assign bus.dispatcher_dest_out      = out_q.dest;
    assign bus.dispatcher_pc_out        = out_q.pc;

    assign bus.lsb_en_out        = lsb_en_q;
    assign bus.lsb_vj_out        = out_q.vj;
    assign bus.lsb_qj_out        = out_q.qj;
    assign bus.lsb_vk_out        = out_q.vk;
    assign bus.lsb_qk_out        = out_q.qk;
    assign bus.lsb_inst_type_out = out_q.inst_type;
    assign bus.lsb_A_out         = out_q.a;
    assign bus.lsb_dest_out      = out_q.dest;
    assign bus.lsb_pc_out        = out_q.pc;

endmodule

// File: tb/tb_dispatcher.sv
// tb_dispatcher: directed scoreboard bench for the dispatcher.
module tb_dispatcher;
    import dispatcher_pkg::*;

    // ---------------- clock / reset ----------------
    logic   clk_in = 1'b0;
    logic   rst_in, rdy_in, rob_flush_in;
    state_e state_out;
    int     cyc = 0;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    dispatcher_if bus();

    dispatcher dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .rob_flush_in(rob_flush_in), .bus(bus), .state_out(state_out)
    );

    // ---------------- scoreboard records ----------------
    typedef struct packed {
        logic [31:0] cyc;
        logic        lsb;
        logic [31:0] vj;
        logic [3:0]  qj;
        logic [31:0] vk;
        logic [3:0]  qk;
        inst_type_e  t;
        logic [31:0] a;
        logic [3:0]  dest;
        logic [31:0] pc;
    } exp_t;
    typedef struct packed {
        logic [31:0] cyc;
        inst_type_e  t;
        logic [4:0]  rd;
        logic [31:0] pc;
    } rob_t;
    typedef struct packed {
        logic [31:0] cyc;
        logic [4:0]  rd;
        logic [3:0]  tag;
    } ren_t;

    localparam int EXP_W = $bits(exp_t);
    localparam int ROB_RW = $bits(rob_t);
    localparam int REN_W = $bits(ren_t);

    logic [EXP_W-1:0]  exp_q[$];
    logic [ROB_RW-1:0] rob_q[$];
    logic [REN_W-1:0]  ren_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic exp_issue(int c, logic lsb, logic [31:0] vj, logic [3:0] qj,
                             logic [31:0] vk, logic [3:0] qk, inst_type_e t,
                             logic [31:0] a, logic [3:0] dest, logic [31:0] pc);
        exp_t e;
        e.cyc = c; e.lsb = lsb; e.vj = vj; e.qj = qj; e.vk = vk; e.qk = qk;
        e.t = t; e.a = a; e.dest = dest; e.pc = pc;
        exp_q.push_back(e);
    endtask

    task automatic exp_rob(int c, inst_type_e t, logic [4:0] rd, logic [31:0] pc);
        rob_t r;
        r.cyc = c; r.t = t; r.rd = rd; r.pc = pc;
        rob_q.push_back(r);
    endtask

    task automatic exp_ren(int c, logic [4:0] rd, logic [3:0] tag);
        ren_t r;
        r.cyc = c; r.rd = rd; r.tag = tag;
        ren_q.push_back(r);
    endtask

    // ---------------- monitor ----------------
    exp_t m_e;
    rob_t m_r;
    ren_t m_n;

    always @(negedge clk_in) begin
        if (bus.dispatcher_en_out || bus.lsb_en_out) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_issue: rs_en=%0b lsb_en=%0b, expected no issue (cycle %0d)",
                         bus.dispatcher_en_out, bus.lsb_en_out, cyc);
            end else begin
                m_e = exp_q.pop_front();
                chk("issue_cycle", cyc, m_e.cyc);
                chk("issue_route", {bus.dispatcher_en_out, bus.lsb_en_out}, m_e.lsb ? 2'b01 : 2'b10);
                if (m_e.lsb) begin
                    chk("lsb_vj", bus.lsb_vj_out, m_e.vj);
                    chk("lsb_qj", bus.lsb_qj_out, m_e.qj);
                    chk("lsb_vk", bus.lsb_vk_out, m_e.vk);
                    chk("lsb_qk", bus.lsb_qk_out, m_e.qk);
                    chk("lsb_type", bus.lsb_inst_type_out, m_e.t);
                    chk("lsb_A", bus.lsb_A_out, m_e.a);
                    chk("lsb_dest", bus.lsb_dest_out, m_e.dest);
                    chk("lsb_pc", bus.lsb_pc_out, m_e.pc);
                end else begin
                    chk("rs_vj", bus.dispatcher_vj_out, m_e.vj);
                    chk("rs_qj", bus.dispatcher_qj_out, m_e.qj);
                    chk("rs_vk", bus.dispatcher_vk_out, m_e.vk);
                    chk("rs_qk", bus.dispatcher_qk_out, m_e.qk);
                    chk("rs_type", bus.dispatcher_inst_type_out, m_e.t);
                    chk("rs_A", bus.dispatcher_A_out, m_e.a);
                    chk("rs_dest", bus.dispatcher_dest_out, m_e.dest);
                    chk("rs_pc", bus.dispatcher_pc_out, m_e.pc);
                end
            end
        end
        if (bus.rob_en_out) begin
            if (rob_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_rob_alloc: rob_en=1, expected 0 (cycle %0d)", cyc);
            end else begin
                m_r = rob_q.pop_front();
                chk("rob_cycle", cyc, m_r.cyc);
                chk("rob_type", bus.rob_inst_type_out, m_r.t);
                chk("rob_rd", bus.rob_rd_out, m_r.rd);
                chk("rob_pc", bus.rob_pc_out, m_r.pc);
            end
        end
        if (bus.reg_rename_en_out) begin
            if (ren_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_rename: rename_en=1 rd=%0d, expected 0 (cycle %0d)",
                         bus.reg_rename_rd_out, cyc);
            end else begin
                m_n = ren_q.pop_front();
                chk("rename_cycle", cyc, m_n.cyc);
                chk("rename_rd", bus.reg_rename_rd_out, m_n.rd);
                chk("rename_tag", bus.reg_rename_tag_out, m_n.tag);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        bus.iq_en_in        = 1'b0;
        bus.iq_inst_type_in = INST_LUI;
        bus.iq_rd_in        = '0;
        bus.iq_rs1_in       = '0;
        bus.iq_rs2_in       = '0;
        bus.iq_imm_in       = '0;
        bus.iq_pc_in        = '0;
        bus.rob_tag_in      = '0;
    endtask

    task automatic set_src(logic [3:0] q1, logic [31:0] v1, logic rr1, logic [31:0] rv1,
                           logic [3:0] q2, logic [31:0] v2, logic rr2, logic [31:0] rv2);
        bus.reg_q1_in = q1; bus.reg_v1_in = v1; bus.rob_rdy1_in = rr1; bus.rob_val1_in = rv1;
        bus.reg_q2_in = q2; bus.reg_v2_in = v2; bus.rob_rdy2_in = rr2; bus.rob_val2_in = rv2;
    endtask

    task automatic set_cdb(logic aen, logic [3:0] ad, logic [31:0] av,
                           logic len, logic [3:0] ld, logic [31:0] lv);
        bus.cdb_alu_en_in = aen; bus.cdb_alu_dest_in = ad; bus.cdb_alu_value_in = av;
        bus.cdb_lbuffer_en_in = len; bus.cdb_lbuffer_dest_in = ld; bus.cdb_lbuffer_value_in = lv;
    endtask

    task automatic send(inst_type_e t, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                        logic [31:0] imm, logic [31:0] pc, logic [3:0] tag);
        bus.iq_en_in = 1'b1; bus.iq_inst_type_in = t; bus.iq_rd_in = rd;
        bus.iq_rs1_in = rs1; bus.iq_rs2_in = rs2; bus.iq_imm_in = imm;
        bus.iq_pc_in = pc; bus.rob_tag_in = tag;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; rob_flush_in = 1'b0;
        idle();
        set_src(0, 0, 0, 0, 0, 0, 0, 0);
        set_cdb(0, 0, 0, 0, 0, 0);
        bus.rs_rdy_in = 1'b1; bus.lsb_rdy_in = 1'b1; bus.rob_free_in = 1'b1;

        // reset values
        #12;
        chk("rst_state", state_out, ST_EMPTY);
        chk("rst_rs_en", bus.dispatcher_en_out, 0);
        chk("rst_lsb_en", bus.lsb_en_out, 0);
        chk("rst_rob_en", bus.rob_en_out, 0);
        chk("rst_rename_en", bus.reg_rename_en_out, 0);
        chk("rst_rename_tag", bus.reg_rename_tag_out, 0);
        chk("rst_dest", bus.dispatcher_dest_out, 0);
        chk("rst_iq_rdy_free", bus.iq_rdy_out, 1);
        bus.rob_free_in = 1'b0; #1;
        chk("rst_iq_rdy_nofree", bus.iq_rdy_out, 0);
        bus.rob_free_in = 1'b1;
        tick();
        rst_in = 1'b1;
        tick();

        // ADDI x1,x0,5: rs1=x0 wins over a busy status; rs2 unused
        set_src(2, 32'h55, 0, 0, 5, 0, 0, 0);
        send(INST_ALU_IMM, 1, 0, 7, 5, 32'h100, 3);
        #1 chk("addi_iq_rdy", bus.iq_rdy_out, 1);
        exp_issue(cyc + 1, 0, 0, 0, 0, 0, INST_ALU_IMM, 5, 3, 32'h100);
        exp_rob(cyc + 1, INST_ALU_IMM, 1, 32'h100);
        exp_ren(cyc + 1, 1, 3);
        tick();

        // ADD x3,x1,x2: x1 busy on tag 3, x2 ready (status beats ROB answer)
        set_src(3, 0, 0, 0, 0, 7, 1, 32'h99);
        send(INST_ALU_REG, 3, 1, 2, 0, 32'h104, 4);
        exp_issue(cyc + 1, 0, 0, 3, 7, 0, INST_ALU_REG, 0, 4, 32'h104);
        exp_rob(cyc + 1, INST_ALU_REG, 3, 32'h104);
        exp_ren(cyc + 1, 3, 4);
        tick();

        // same, with ALU CDB broadcasting tag 3 in the accept cycle
        set_cdb(1, 3, 9, 0, 0, 0);
        send(INST_ALU_REG, 3, 1, 2, 0, 32'h108, 5);
        exp_issue(cyc + 1, 0, 9, 0, 7, 0, INST_ALU_REG, 0, 5, 32'h108);
        exp_rob(cyc + 1, INST_ALU_REG, 3, 32'h108);
        exp_ren(cyc + 1, 3, 5);
        tick();

        // ROB answer beats CDB on rs1; load-buffer CDB resolves rs2
        set_src(3, 0, 1, 32'h11, 6, 32'h5, 0, 0);
        set_cdb(1, 3, 32'h33, 1, 6, 32'h22);
        send(INST_ALU_REG, 4, 1, 2, 0, 32'h10c, 6);
        exp_issue(cyc + 1, 0, 32'h11, 0, 32'h22, 0, INST_ALU_REG, 0, 6, 32'h10c);
        exp_rob(cyc + 1, INST_ALU_REG, 4, 32'h10c);
        exp_ren(cyc + 1, 4, 6);
        tick();
        set_cdb(0, 0, 0, 0, 0, 0);

        // LW x6,8(x1) with LSB busy: HOLD, CDB clears qj while waiting
        set_src(4, 0, 0, 0, 2, 0, 0, 0);
        bus.lsb_rdy_in = 1'b0;
        send(INST_LOAD, 6, 1, 9, 8, 32'h200, 7);
        exp_rob(cyc + 1, INST_LOAD, 6, 32'h200);
        exp_ren(cyc + 1, 6, 7);
        tick();
        set_src(0, 0, 0, 0, 0, 0, 0, 0);
        send(INST_ALU_REG, 7, 1, 2, 0, 32'h999, 8);   // must not be taken while holding
        #1;
        chk("ld_hold_state", state_out, ST_HOLD);
        chk("ld_hold_iq_rdy", bus.iq_rdy_out, 0);
        tick();
        set_cdb(1, 4, 32'h40, 0, 0, 0);
        tick();
        set_cdb(0, 0, 0, 0, 0, 0);
        tick();
        idle();
        bus.lsb_rdy_in = 1'b1;
        exp_issue(cyc + 1, 1, 32'h40, 0, 0, 0, INST_LOAD, 8, 7, 32'h200);
        tick();
        chk("ld_after_state", state_out, ST_EMPTY);
        chk("ld_after_iq_rdy", bus.iq_rdy_out, 1);

        // SW held; load-buffer CDB in the issue cycle lands in the bundle
        set_src(0, 32'h1000, 0, 0, 5, 0, 0, 0);
        bus.lsb_rdy_in = 1'b0;
        send(INST_STORE, 0, 2, 3, 12, 32'h300, 8);
        exp_rob(cyc + 1, INST_STORE, 0, 32'h300);
        tick();
        idle();
        set_src(0, 0, 0, 0, 0, 0, 0, 0);
        bus.lsb_rdy_in = 1'b1;
        set_cdb(0, 0, 0, 1, 5, 32'h77);
        exp_issue(cyc + 1, 1, 32'h1000, 0, 32'h77, 0, INST_STORE, 12, 8, 32'h300);
        tick();
        set_cdb(0, 0, 0, 0, 0, 0);

        // BEQ held in RS path; rdy_in low freezes HOLD even with slot ready
        set_src(0, 3, 0, 0, 0, 3, 0, 0);
        bus.rs_rdy_in = 1'b0;
        send(INST_BRANCH, 0, 1, 2, 32'h10, 32'h400, 9);
        exp_rob(cyc + 1, INST_BRANCH, 0, 32'h400);
        tick();
        idle();
        rdy_in = 1'b0;
        bus.rs_rdy_in = 1'b1;
        tick();
        tick();
        chk("frz_state", state_out, ST_HOLD);
        rdy_in = 1'b1;
        exp_issue(cyc + 1, 0, 3, 0, 3, 0, INST_BRANCH, 32'h10, 9, 32'h400);
        tick();

        // no free ROB entry: nothing accepted
        bus.rob_free_in = 1'b0;
        send(INST_ALU_REG, 5, 1, 2, 0, 32'h450, 10);
        #1 chk("nofree_iq_rdy", bus.iq_rdy_out, 0);
        tick();
        chk("nofree_rob_en", bus.rob_en_out, 0);
        chk("nofree_state", state_out, ST_EMPTY);
        bus.rob_free_in = 1'b1;
        idle();

        // rd=x0: no rename; JAL: sources forced ready, rename x1
        set_src(0, 1, 0, 0, 0, 2, 0, 0);
        send(INST_ALU_REG, 0, 1, 2, 0, 32'h500, 10);
        exp_issue(cyc + 1, 0, 1, 0, 2, 0, INST_ALU_REG, 0, 10, 32'h500);
        exp_rob(cyc + 1, INST_ALU_REG, 0, 32'h500);
        tick();
        set_src(3, 0, 0, 0, 3, 0, 0, 0);
        send(INST_JAL, 1, 5, 6, 32'h20, 32'h504, 11);
        exp_issue(cyc + 1, 0, 0, 0, 0, 0, INST_JAL, 32'h20, 11, 32'h504);
        exp_rob(cyc + 1, INST_JAL, 1, 32'h504);
        exp_ren(cyc + 1, 1, 11);
        tick();
        idle();

        // flush in HOLD beats a ready target
        set_src(2, 0, 0, 0, 0, 0, 0, 0);
        bus.lsb_rdy_in = 1'b0;
        send(INST_LOAD, 2, 3, 0, 0, 32'h600, 12);
        exp_rob(cyc + 1, INST_LOAD, 2, 32'h600);
        exp_ren(cyc + 1, 2, 12);
        tick();
        idle();
        rob_flush_in = 1'b1;
        bus.lsb_rdy_in = 1'b1;
        tick();
        rob_flush_in = 1'b0;
        chk("flush_state", state_out, ST_EMPTY);
        chk("flush_iq_rdy", bus.iq_rdy_out, 1);
        chk("flush_lsb_en", bus.lsb_en_out, 0);
        tick();

        // flush beats accept
        set_src(0, 0, 0, 0, 0, 0, 0, 0);
        rob_flush_in = 1'b1;
        send(INST_ALU_IMM, 4, 0, 0, 1, 32'h650, 13);
        tick();
        rob_flush_in = 1'b0;
        idle();
        chk("flush_acc_rob_en", bus.rob_en_out, 0);
        chk("flush_acc_rename_en", bus.reg_rename_en_out, 0);

        // asynchronous reset in the middle of HOLD
        set_src(5, 0, 0, 0, 0, 0, 0, 0);
        bus.lsb_rdy_in = 1'b0;
        send(INST_LOAD, 7, 1, 0, 0, 32'h700, 14);
        exp_rob(cyc + 1, INST_LOAD, 7, 32'h700);
        exp_ren(cyc + 1, 7, 14);
        tick();
        idle();
        #6;
        chk("arst_pre_state", state_out, ST_HOLD);
        chk("arst_pre_tag", bus.reg_rename_tag_out, 14);
        rst_in = 1'b0;
        #1;
        chk("arst_state", state_out, ST_EMPTY);
        chk("arst_rename_tag", bus.reg_rename_tag_out, 0);
        chk("arst_rename_rd", bus.reg_rename_rd_out, 0);
        chk("arst_rs_dest", bus.dispatcher_dest_out, 0);
        chk("arst_lsb_dest", bus.lsb_dest_out, 0);
        chk("arst_iq_rdy", bus.iq_rdy_out, 1);
        bus.lsb_rdy_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b1;
        tick();
        tick();

        chk("issue_q_drained", exp_q.size(), 0);
        chk("rob_q_drained", rob_q.size(), 0);
        chk("rename_q_drained", ren_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dispatcher.md
# dispatcher

Issue stage between the instruction queue and the out-of-order back end. Each cycle it takes at most one decoded instruction and allocates it a ROB tag. It resolves source operands through the register-status table, the ROB and both CDB buses, renames `rd`, and sends the instruction to the reservation station (ALU/branch/jump classes) or the load/store buffer (load/store classes). A one-entry hold register absorbs back-pressure and keeps snooping the CDB while it waits.

## Interface
- `ROB_W`, 4: ROB tag width; tag 0 is NULL ("value ready"), so tags 1..15 are valid.
- `DATA_W`, 32: operand/immediate/pc width.
- `clk_in`  in  1  clock; all state updates on rising edge.
- `rst_in`  in  1  reset, asynchronous, active-low.
- `rdy_in`  in  1  global enable; when low, all state freezes.
- `rob_flush_in`  in  1  mispredict flush.
- `iq_en_in`  in  1  instruction-queue entry valid.
- `iq_inst_type_in`, `iq_rd_in`, `iq_rs1_in`, `iq_rs2_in`, `iq_imm_in`, `iq_pc_in`  in  `INST_TYPE_WIDTH`/5/5/5/`DATA_W`/`DATA_W`  decoded fields.
- `iq_rdy_out`  out  1  dispatcher can accept this cycle.
- `rob_free_in`  in  1  ROB has a free entry.
- `rob_tag_in`  in  `ROB_W`  next free ROB tag.
- `rob_en_out`, `rob_inst_type_out`, `rob_rd_out`, `rob_pc_out`  out  1/type/5/`DATA_W`  ROB allocate.
- `reg_rs1_out`, `reg_rs2_out`  out  5  combinational status query.
- `reg_q1_in`, `reg_v1_in`, `reg_q2_in`, `reg_v2_in`  in  `ROB_W`/`DATA_W`  status tag and architectural value.
- `rob_q1_out`, `rob_q2_out`  out  `ROB_W`  ROB value query.
- `rob_rdy1_in`, `rob_val1_in`, `rob_rdy2_in`, `rob_val2_in`  in  1/`DATA_W`  ROB result available.
- `reg_rename_en_out`, `reg_rename_rd_out`, `reg_rename_tag_out`  out  1/5/`ROB_W`.
- `rs_rdy_in`, `lsb_rdy_in`  in  1  target has a free slot next cycle.
- `dispatcher_en_out`, `dispatcher_vj_out`, `dispatcher_qj_out`, `dispatcher_vk_out`, `dispatcher_qk_out`, `dispatcher_inst_type_out`, `dispatcher_A_out`, `dispatcher_dest_out`, `dispatcher_pc_out`  out  RS issue bundle, registered.
- `lsb_en_out` plus the same nine-field bundle  out  LSB issue bundle, registered.
- `cdb_alu_en_in`/`_dest_in`/`_value_in`, `cdb_lbuffer_en_in`/`_dest_in`/`_value_in`  in  CDB snoop.

## Operation
- States: EMPTY and HOLD. In EMPTY, `iq_rdy_out = rob_free_in`. In HOLD, `iq_rdy_out = 0`.
- Accept when `iq_en_in & iq_rdy_out`. On accept, the ROB allocate, rename and target bundle are all produced from the same decoded instruction.
- Operand resolution, per source, highest priority first:
  - `rs == 0` gives q=0, v=0.
  - `reg_q == 0` gives `reg_v`.
  - `rob_rdy` gives `rob_val`.
  - A CDB hit on either bus gives that bus value.
  - Otherwise q = `reg_q`.
- Sources the type does not use force q=0, v=0. LUI/AUIPC/JAL use no sources; immediate forms and JALR use rs1 only; loads use rs1 only; R-type, branches and stores use both.
- `A` = `iq_imm_in`; `dest` = `rob_tag_in`.
- Rename fires only when the type writes rd and `rd != 0`. Sources are read before the rename: for `add x5,x5,x1`, rs1 resolves the old mapping of x5.
- Route loads/stores to the LSB and everything else to the RS.
  - Target ready at accept: pulse the target enable next cycle and stay in EMPTY.
  - Target not ready: latch into HOLD. ROB allocate and rename still fire at accept.
- In HOLD, both CDB buses are snooped every cycle and clear matching q fields. The entry issues on the first cycle the target ready is high, then returns to EMPTY.
- Flush: all enables go 0 next edge, state goes to EMPTY and HOLD contents are discarded. Flush has priority over accept and over issue.

## Timing
- Reset values: every `*_en_out`, bundle field, rename output and state = 0/EMPTY. `iq_rdy_out` follows `rob_free_in`.
- Latency: accept at edge t, then `rob_en_out`, `reg_rename_en_out` and the target enable are high for exactly cycle t+1.
- All enables are single-cycle pulses, with no two dispatches in consecutive cycles from HOLD.
- A CDB broadcast in the accept cycle is captured. A CDB broadcast in the issue cycle of HOLD is captured in the bundle.
- `rdy_in` low: no accept, no issue, enables low, HOLD retained.
- Reset asserted mid-HOLD: immediate clear, no issue.

## Structure
- Shared `define.vh`: `INST_TYPE_WIDTH`, type codes, `ROB_WIDTH`, `NULL`, `ENABLE`/`DISABLE`.
- One sub-module, `operand_resolve`: combinational priority mux for a single source. It is instantiated twice and reused for the HOLD snoop.

## Test plan
- ADDI x1,x0,5, all ready, `rob_tag_in=3` → at t+1: RS en, vj=0, qj=0, A=5, dest=3, rename x1→3.
- ADD x3,x1,x2 with x1 q=3 (not ready) and x2 value 7 → qj=3, vk=7, qk=0. In the same cycle CDB alu dest=3 value=9 → vj=9, qj=0.
- LW with `lsb_rdy_in=0` for 3 cycles → HOLD, `iq_rdy_out=0`. CDB clears qj in cycle 2. LSB en in the cycle after `lsb_rdy_in` rises, with qj=0.
- `rob_free_in=0` → `iq_rdy_out=0`, no enables.
- Flush during HOLD → next cycle no enable, EMPTY, `iq_rdy_out=1`.
- Instruction with `rd=0` → no rename pulse. Async reset mid-HOLD → all outputs 0 without a clock edge.
